// File: rtl/riscv_exc_ctrl_vec_if.sv
// Handshake and cause/PC-select bundle between the exception controller and the core controller.
interface riscv_exc_ctrl_vec_if #(
  parameter int unsigned IRQ_ID_W = 5
);
  logic                req_o;
  logic                ack_i;
  logic                trap_o;
  logic [1:0]          pc_mux_o;
  logic [IRQ_ID_W-1:0] vec_pc_mux_o;
  logic [5:0]          cause_o;
  logic                save_cause_o;

  modport master (
    output req_o, trap_o, pc_mux_o, vec_pc_mux_o, cause_o, save_cause_o,
    input  ack_i
  );

  modport slave (
    input  req_o, trap_o, pc_mux_o, vec_pc_mux_o, cause_o, save_cause_o,
    output ack_i
  );
endinterface

// File: rtl/riscv_exc_ctrl_vec.sv
// Exception/interrupt controller: arbitrates decoder/LSU exceptions and masked IRQ lines into one core request.
// Optional edge-triggered pending capture is enabled by defining RISCV_IRQ_EDGE_EN.
module riscv_exc_ctrl_vec #(
  parameter int unsigned NUM_IRQ    = 32,
  parameter int unsigned IRQ_ID_W   = 5,
  parameter logic [31:0] EDGE_MASK  = 32'h0,
  parameter int unsigned DBG_SETS_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_exc_ctrl_vec_if.master  ctrl,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic [NUM_IRQ-1:0]    irq_mask_i,
  input  logic                  irq_enable_i,
  input  logic                  ebrk_insn_i,
  input  logic                  ecall_insn_i,
  input  logic                  illegal_insn_i,
  input  logic                  lsu_load_err_i,
  input  logic                  lsu_store_err_i,
  output logic                  irq_ack_o,
  output logic [IRQ_ID_W-1:0]   irq_id_o,
  input  logic [DBG_SETS_W-1:0] dbg_settings_i
);

  localparam int unsigned CAUSE_W = 6;

  localparam int unsigned DBG_SETS_SSTE  = 0;
  localparam int unsigned DBG_SETS_EBRK  = 1;
  localparam int unsigned DBG_SETS_ELSU  = 2;
  localparam int unsigned DBG_SETS_EILL  = 3;
  localparam int unsigned DBG_SETS_ECALL = 4;
  localparam int unsigned DBG_SETS_IRQ   = 5;

  localparam logic [1:0] EXC_PC_ILLINSN = 2'b00;
  localparam logic [1:0] EXC_PC_ECALL   = 2'b01;
  localparam logic [1:0] EXC_PC_LOAD    = 2'b10;
  localparam logic [1:0] EXC_PC_STORE   = 2'b10;
  localparam logic [1:0] EXC_PC_IRQ     = 2'b11;

  typedef enum logic [0:0] {IDLE, WAIT_CTRL} state_e;

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   irq_src;
  logic [NUM_IRQ-1:0]   irq_eff;
  logic [IRQ_ID_W-1:0]  irq_idx;
  logic [IRQ_ID_W-1:0]  taken_idx;
  logic                 irq_req;
  logic                 req_int;
  logic                 is_irq_int;
  logic [CAUSE_W-1:0]   cause_int;
  logic [1:0]           pc_mux_int;
  logic [CAUSE_W-1:0]   cause_q;
  logic [1:0]           pc_mux_q;
  logic                 is_irq_q;
  logic                 cap_en;
  logic                 in_idle;

`ifdef RISCV_IRQ_EDGE_EN
  localparam logic [NUM_IRQ-1:0] EDGE_LINES = EDGE_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] clr_vec;

  assign clr_vec = NUM_IRQ'(irq_ack_o) << taken_idx;
  assign irq_src = (irq_i & ~EDGE_LINES) | (pend_q & EDGE_LINES);

  // A fresh edge in the same cycle as the clear keeps the pending bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_i & EDGE_LINES;
      pend_q <= (pend_q & ~clr_vec) | (irq_i & ~irq_q & EDGE_LINES);
    end
  end
`else
  logic unused_edge_mask;

  assign unused_edge_mask = ^EDGE_MASK;
  assign irq_src          = irq_i;
`endif

  assign irq_eff = irq_src & irq_mask_i;
  assign irq_req = irq_enable_i & (|irq_eff);
  assign req_int = ecall_insn_i | lsu_load_err_i | lsu_store_err_i | illegal_insn_i | irq_req;
  assign in_idle = (state_q == IDLE);

  // Lowest-numbered active line wins.
  always_comb begin
    irq_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (irq_eff[i]) irq_idx = IRQ_ID_W'(i);
    end
  end

  // Cause / PC select priority; ebreak only forces the cause.
  always_comb begin
    cause_int  = '0;
    pc_mux_int = pc_mux_q;
    is_irq_int = 1'b0;
    if (lsu_store_err_i) begin
      cause_int  = 6'h07;
      pc_mux_int = EXC_PC_STORE;
    end else if (lsu_load_err_i) begin
      cause_int  = 6'h05;
      pc_mux_int = EXC_PC_LOAD;
    end else if (illegal_insn_i) begin
      cause_int  = 6'h02;
      pc_mux_int = EXC_PC_ILLINSN;
    end else if (ecall_insn_i) begin
      cause_int  = 6'h0B;
      pc_mux_int = EXC_PC_ECALL;
    end else if (ebrk_insn_i) begin
      cause_int  = 6'h03;
    end else if (irq_req) begin
      cause_int  = {1'b1, 5'(irq_idx)};
      pc_mux_int = EXC_PC_IRQ;
      is_irq_int = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req_int && !ctrl.ack_i) state_d = WAIT_CTRL;
      WAIT_CTRL: if (ctrl.ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl.req_o        = 1'b0;
    ctrl.save_cause_o = 1'b0;
    irq_ack_o         = 1'b0;
    cap_en            = 1'b0;
    taken_idx         = cause_q[IRQ_ID_W-1:0];
    case (state_q)
      IDLE: begin
        ctrl.req_o        = req_int;
        ctrl.save_cause_o = req_int & ctrl.ack_i;
        irq_ack_o         = req_int & ctrl.ack_i & is_irq_int;
        cap_en            = req_int;
        taken_idx         = irq_idx;
      end
      WAIT_CTRL: begin
        ctrl.req_o        = 1'b1;
        ctrl.save_cause_o = ctrl.ack_i;
        irq_ack_o         = ctrl.ack_i & is_irq_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q  <= '0;
      pc_mux_q <= '0;
      is_irq_q <= 1'b0;
    end else if (cap_en) begin
      cause_q  <= cause_int;
      pc_mux_q <= pc_mux_int;
      is_irq_q <= is_irq_int;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         irq_id_o <= '0;
    else if (irq_ack_o) irq_id_o <= taken_idx;
  end

  assign ctrl.cause_o      = ((in_idle && req_int) || ebrk_insn_i) ? cause_int : cause_q;
  assign ctrl.pc_mux_o     = (in_idle && req_int) ? pc_mux_int : pc_mux_q;
  assign ctrl.vec_pc_mux_o = ctrl.cause_o[IRQ_ID_W-1:0];

  assign ctrl.trap_o = dbg_settings_i[DBG_SETS_SSTE]
                     | (ecall_insn_i & dbg_settings_i[DBG_SETS_ECALL])
                     | ((lsu_load_err_i | lsu_store_err_i) & dbg_settings_i[DBG_SETS_ELSU])
                     | (ebrk_insn_i & dbg_settings_i[DBG_SETS_EBRK])
                     | (illegal_insn_i & dbg_settings_i[DBG_SETS_EILL])
                     | (irq_req & dbg_settings_i[DBG_SETS_IRQ]);

endmodule
